// File: rtl/stim_serializer.sv
// Parallel-to-serial stimulus driver: shifts a WIDTH-bit word out MSB first,
// holding each bit DIV cycles. Back-to-back words are accepted in a word's last cycle.
module stim_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   DIV        = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             in,
  output logic             out_valid,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_TOP = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_TOP = DW'(DIV - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [BW-1:0]    r_bit_cnt;
  logic [DW-1:0]    r_div_cnt;
  logic             r_ready;
  logic             r_in;
  logic             r_out_valid;
  logic             r_done;

  logic w_transfer;
  logic w_div_end;
  logic w_last;

  // ready is registered, so a transfer is only ever possible in IDLE or the last cycle.
  assign w_transfer = valid && r_ready;
  assign w_div_end  = (r_div_cnt == DIV_TOP);
  assign w_last     = (r_state == S_SHIFT) && (r_bit_cnt == '0) && w_div_end;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_div_cnt   <= '0;
      r_ready     <= 1'b1;
      r_in        <= IDLE_LEVEL;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else if (w_transfer) begin
      r_state     <= S_SHIFT;
      r_sr        <= data_in;
      r_bit_cnt   <= BIT_TOP;
      r_div_cnt   <= '0;
      r_in        <= data_in[WIDTH-1];
      r_out_valid <= 1'b1;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      if (w_last) begin
        r_state     <= S_IDLE;
        r_sr        <= '0;
        r_bit_cnt   <= '0;
        r_div_cnt   <= '0;
        r_in        <= IDLE_LEVEL;
        r_out_valid <= 1'b0;
        r_ready     <= 1'b1;
        r_done      <= 1'b0;
      end else if (w_div_end) begin
        r_sr      <= {r_sr[WIDTH-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt - BW'(1);
        r_div_cnt <= '0;
        r_in      <= r_sr[WIDTH-2];
        // Next cycle is the last one only when each bit lasts a single cycle.
        r_ready   <= (r_bit_cnt == BW'(1)) && (DIV == 1);
        r_done    <= (r_bit_cnt == BW'(1)) && (DIV == 1);
      end else begin
        r_div_cnt <= r_div_cnt + DW'(1);
        r_ready   <= (r_bit_cnt == '0) && (r_div_cnt == DW'(DIV - 2));
        r_done    <= (r_bit_cnt == '0) && (r_div_cnt == DW'(DIV - 2));
      end
    end
  end

  assign ready     = r_ready;
  assign in        = r_in;
  assign out_valid = r_out_valid;
  assign done      = r_done;

endmodule

// File: tb/tb_stim_serializer.sv
// Bench for stim_serializer: DIV=4 and DIV=1 instances share stimulus and are
// each compared every cycle against a queue of expected per-cycle line values.
module tb_stim_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         Reset;
  logic [W-1:0] data_in;
  logic         valid;

  logic ready4, in4, ov4, done4;
  logic ready1, in1, ov1, done1;

  int n_cmp = 0;
  int n_err = 0;

  // Each entry is one expected cycle: {line bit, last-cycle-of-word flag}.
  logic [1:0] q4[$];
  logic [1:0] q1[$];

  always #5 clk = ~clk;

  stim_serializer #(.WIDTH(W), .DIV(4), .IDLE_LEVEL(1'b0)) dut4 (
    .clk(clk), .Reset(Reset), .data_in(data_in), .valid(valid),
    .ready(ready4), .in(in4), .out_valid(ov4), .done(done4)
  );

  stim_serializer #(.WIDTH(W), .DIV(1), .IDLE_LEVEL(1'b0)) dut1 (
    .clk(clk), .Reset(Reset), .data_in(data_in), .valid(valid),
    .ready(ready1), .in(in1), .out_valid(ov1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [1:0] e4, e1;
    logic       busy4, busy1;
    busy4 = (q4.size() != 0);
    busy1 = (q1.size() != 0);
    e4 = busy4 ? q4[0] : 2'b00;
    e1 = busy1 ? q1[0] : 2'b00;
    check({tag, "/in4"},    in4,    e4[1]);
    check({tag, "/ov4"},    ov4,    busy4);
    check({tag, "/done4"},  done4,  e4[0]);
    check({tag, "/ready4"}, ready4, !busy4 || e4[0]);
    check({tag, "/in1"},    in1,    e1[1]);
    check({tag, "/ov1"},    ov1,    busy1);
    check({tag, "/done1"},  done1,  e1[0]);
    check({tag, "/ready1"}, ready1, !busy1 || e1[0]);
  endtask

  // Advance the reference by one rising edge with the inputs that were applied.
  task automatic model_edge(input logic v, input logic [W-1:0] d, input logic r);
    logic rdy4, rdy1;
    rdy4 = (q4.size() == 0) || q4[0][0];
    rdy1 = (q1.size() == 0) || q1[0][0];
    if (q4.size() != 0) void'(q4.pop_front());
    if (q1.size() != 0) void'(q1.pop_front());
    if (v && !r && rdy4)
      for (int b = W - 1; b >= 0; b--)
        for (int k = 0; k < 4; k++) q4.push_back({d[b], (b == 0) && (k == 3)});
    if (v && !r && rdy1)
      for (int b = W - 1; b >= 0; b--) q1.push_back({d[b], b == 0});
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input string tag);
    @(negedge clk);
    check_all(tag);
    valid   = v;
    data_in = d;
    Reset   = r;
    if (r) begin
      q4.delete();
      q1.delete();
    end
    @(posedge clk);
    model_edge(v, d, r);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b0, tag);
  endtask

  initial begin
    Reset   = 1'b1;
    valid   = 1'b0;
    data_in = '0;
    #1;
    check_all("reset");
    for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), 1'b1, "rst_valid");
    step(1'b0, '0, 1'b0, "release");
    idle(5, "idle");

    step(1'b1, 8'hF0, 1'b0, "f0_xfer");
    idle(40, "f0");

    step(1'b1, 8'hF0, 1'b0, "b2b_xfer");
    for (int i = 0; i < 32; i++) step(1'b1, 8'h0F, 1'b0, "b2b_hold");
    idle(70, "b2b");

    step(1'b1, 8'hAA, 1'b0, "aa_xfer");
    for (int i = 0; i < 30; i++) step(1'b1, 8'h00, 1'b0, "aa_ignore");
    idle(40, "aa");

    step(1'b1, 8'hA5, 1'b0, "a5_xfer");
    idle(40, "a5");

    // Abort a word with an asynchronous reset in the middle of its 10th cycle.
    step(1'b1, 8'hFF, 1'b0, "ff_xfer");
    for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b0, "ff");
    #2;
    Reset = 1'b1;
    q4.delete();
    q1.delete();
    #1;
    check_all("async_rst");
    step(1'b0, '0, 1'b1, "rst_hold");
    step(1'b1, 8'h55, 1'b1, "rst_hold_v");
    step(1'b0, '0, 1'b0, "rst_release");
    step(1'b1, 8'h81, 1'b0, "x81_xfer");
    idle(40, "x81");

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, W'($urandom), 1'b0, "rand");
    idle(40, "drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
